prog_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 12 +
 rtl/timer_prescaler.sv | 31 +++
 rtl/prog_timer.sv | 102 ++++++++++
 tb/tb_prog_timer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default sizing for the programmable timer.
package timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int TIMER_WIDTH_DEF = 24;
  localparam int TIMER_PRE_W_DEF = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: asserts tick once every div+1 enabled cycles.
// clr restarts the division phase so a fresh run begins at a known point.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // The tick is decoded from the phase counter so the top sees it in the same cycle.
  assign tick = en && (cnt == div);

  // Phase counter: runs 0..div while enabled, wraps on tick, restarts on clr.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable timer: counts prescaled ticks up to a latched terminal value
// and pulses counted on each expiry, in one-shot or periodic mode.
// Optional feature macro: PROG_TIMER_STICKY_EN adds a sticky expiry flag
// (input clr_flag, output flag).
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEF,
  parameter int PRE_W = TIMER_PRE_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] num,
  input  logic [PRE_W-1:0] prescale,
  output logic             busy,
  output logic             counted,
  output logic [WIDTH-1:0] count
`ifdef PROG_TIMER_STICKY_EN
  ,
  input  logic             clr_flag,
  output logic             flag
`endif
);

  timer_state_t     state;
  logic [WIDTH-1:0] target_l;
  logic [PRE_W-1:0] pre_l;
  logic             per_l;
  logic             tick;
  logic             load;
  logic             expire;

  // A start without stop (re)loads the timer from IDLE or from RUN alike.
  assign load   = start && !stop;
  // Expiry needs an undisturbed RUN cycle: stop or restart on that edge suppresses it.
  assign expire = (state == RUN) && !stop && !start && tick && (count == target_l);

  timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (load),
    .div   (pre_l),
    .tick  (tick)
  );

  // Control FSM with registered outputs; stop beats start, start beats tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      counted  <= 1'b0;
      count    <= '0;
      target_l <= '0;
      pre_l    <= '0;
      per_l    <= 1'b0;
    end else begin
      counted <= expire;
      if (stop) begin
        // count is left untouched so software can read where the run stopped.
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        target_l <= num;
        pre_l    <= prescale;
        per_l    <= periodic;
        count    <= '0;
        state    <= RUN;
        busy     <= 1'b1;
      end else if ((state == RUN) && tick) begin
        if (count == target_l) begin
          count <= '0;
          if (!per_l) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

`ifdef PROG_TIMER_STICKY_EN
  // Sticky expiry flag; a new expiry takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (expire) begin
      flag <= 1'b1;
    end else if (clr_flag) begin
      flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed literal checks plus a
// randomized phase, all compared every cycle against an elapsed-time model.
module tb_prog_timer;

  localparam int WIDTH = 24;
  localparam int PRE_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] num;
  logic [PRE_W-1:0] prescale;
  logic             busy;
  logic             counted;
  logic [WIDTH-1:0] count;
`ifdef PROG_TIMER_STICKY_EN
  logic             clr_flag;
  logic             flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: the timer is described by elapsed RUN cycles since the last load.
  bit     m_run     = 1'b0;
  longint m_k       = 0;
  longint m_n       = 0;
  longint m_p       = 0;
  bit     m_per     = 1'b0;
  longint m_count   = 0;
  bit     m_counted = 1'b0;
  bit     m_flag    = 1'b0;

  prog_timer #(
    .WIDTH (WIDTH),
    .PRE_W (PRE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .num      (num),
    .prescale (prescale),
    .busy     (busy),
    .counted  (counted),
    .count    (count)
`ifdef PROG_TIMER_STICKY_EN
    ,
    .clr_flag (clr_flag),
    .flag     (flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // After k RUN cycles, ticks = k/(P+1); an expiry lands whenever ticks is a
  // multiple of N+1, and the visible count is ticks mod (N+1).
  task automatic model_step();
    bit     expire;
    longint ticks;
    expire    = 1'b0;
    m_counted = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_k = 0; m_n = 0; m_p = 0; m_per = 1'b0; m_count = 0; m_flag = 1'b0;
    end else begin
      if (stop) begin
        m_run = 1'b0;
      end else if (start) begin
        m_n = longint'(num); m_p = longint'(prescale); m_per = periodic;
        m_k = 0; m_count = 0; m_run = 1'b1;
      end else if (m_run) begin
        m_k++;
        if (m_k % (m_p + 1) == 0) begin
          ticks   = m_k / (m_p + 1);
          m_count = ticks % (m_n + 1);
          if (m_count == 0) begin
            expire = 1'b1;
            if (!m_per) m_run = 1'b0;
          end
        end
      end
      m_counted = expire;
`ifdef PROG_TIMER_STICKY_EN
      if (expire) m_flag = 1'b1;
      else if (clr_flag) m_flag = 1'b0;
`endif
    end
  endtask

  always @(posedge clk) model_step();

  task automatic compare();
    check("busy_vs_model", busy, m_run);
    check("counted_vs_model", counted, m_counted);
    check("count_vs_model", count, m_count);
`ifdef PROG_TIMER_STICKY_EN
    check("flag_vs_model", flag, m_flag);
`endif
  endtask

  always @(negedge clk) if (cmp_en) compare();

  task automatic cyc();
    @(negedge clk);
  endtask

  // Pulse start for one edge with the given configuration.
  task automatic kick(input int n, input int p, input bit per);
    num = WIDTH'(n); prescale = PRE_W'(p); periodic = per; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget);
    int i;
    i = 0;
    while ((count !== WIDTH'(target)) && (i < budget)) begin
      cyc();
      i++;
    end
    check("wait_count", count, target);
  endtask

  initial begin
    logic [WIDTH-1:0] seq3 [8];
    reset = 1'b1; start = 1'b1; stop = 1'b0; periodic = 1'b0; num = '0; prescale = '0;
`ifdef PROG_TIMER_STICKY_EN
    clr_flag = 1'b0;
`endif
    @(posedge clk);
    cmp_en = 1'b1;

    // Reset held with start asserted: nothing may run.
    repeat (2) begin
      cyc();
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      check("rst_counted", counted, 0);
    end
    reset = 1'b0; start = 1'b0;
    repeat (3) begin
      cyc();
      check("idle_after_rst_busy", busy, 0);
    end

    // One-shot, N=5, P=0: single pulse 6 cycles after the start edge.
    kick(5, 0, 1'b0);
    check("os_busy_start", busy, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("os_counted", counted, (i == 6));
      check("os_busy", busy, (i < 6));
    end

    // Periodic, N=3, P=1: count 0,0,1,1,2,2,3,3 and a pulse every 8 cycles.
    seq3[0] = 0; seq3[1] = 0; seq3[2] = 1; seq3[3] = 1;
    seq3[4] = 2; seq3[5] = 2; seq3[6] = 3; seq3[7] = 3;
    kick(3, 1, 1'b1);
    for (int i = 0; i < 26; i++) begin
      if (i > 0) cyc();
      check("per_count_seq", count, seq3[i % 8]);
      check("per_counted", counted, (i > 0) && (i % 8 == 0));
    end

    // Periodic N=9, stop at count 4: freezes at 4 with no pulse.
    kick(9, 0, 1'b1);
    wait_count(4, 20);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_count_hold", count, 4);
    check("stop_counted", counted, 0);
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    check("stop_start_busy", busy, 0);
    repeat (3) cyc();
    check("stop_count_frozen", count, 4);

    // Restart mid-run with N=2: count clears, pulse 3 cycles later.
    kick(10, 0, 1'b0);
    wait_count(6, 20);
    kick(2, 0, 1'b0);
    check("restart_count", count, 0);
    check("restart_busy", busy, 1);
    check("restart_counted", counted, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("restart_pulse", counted, (i == 3));
    end

    // N=0, periodic, P=0: counted continuously high.
    kick(0, 0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("n0_counted", counted, 1);
      check("n0_count", count, 0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Maximum terminal value is legal and just counts up.
    kick((1 << WIDTH) - 1, 0, 1'b0);
    repeat (3) cyc();
    check("max_count", count, 3);
    check("max_counted", counted, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

`ifdef PROG_TIMER_STICKY_EN
    // Sticky flag: set on expiry, holds, set wins over clear, clear alone drops it.
    clr_flag = 1'b1;
    cyc();
    clr_flag = 1'b0;
    check("flag_cleared", flag, 0);
    kick(2, 0, 1'b0);
    repeat (3) cyc();
    check("flag_set", flag, 1);
    repeat (20) cyc();
    check("flag_hold", flag, 1);
    kick(2, 0, 1'b0);
    repeat (2) cyc();
    clr_flag = 1'b1;
    cyc();
    clr_flag = 1'b0;
    check("flag_set_wins_pulse", counted, 1);
    check("flag_set_wins", flag, 1);
    clr_flag = 1'b1;
    cyc();
    clr_flag = 1'b0;
    check("flag_clr_alone", flag, 0);
`endif

    // Randomized phase: the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 14) == 0);
      stop     = ($urandom_range(0, 24) == 0);
      periodic = $urandom_range(0, 1) == 1;
      num      = WIDTH'($urandom_range(0, 12));
      prescale = PRE_W'($urandom_range(0, 3));
`ifdef PROG_TIMER_STICKY_EN
      clr_flag = ($urandom_range(0, 7) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
